// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              cpu_ack;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [WIDTH-1:0]  ext_wdata;
  logic [WIDTH-1:0]  ext_rdata;
  logic              ext_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              stall;
  logic              owner;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall, owner
  );

  // requester / memory environment side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for the unified memory port
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  cpu_rdata_q;
  logic [WIDTH-1:0]  ext_rdata_q;
  logic              owner_q;
  logic              last_grant;
  logic              grant_valid;
  logic              grant_who;
  logic              tie;
  logic              last_beat;
  logic              mem_en_c;
  logic              mem_we_c;
  logic              cpu_ack_c;
  logic              ext_ack_c;

  assign last_beat = (state == ACCESS) && (cnt == 4'(MEM_LAT - 1));

  // pick a winner: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    tie         = bus.cpu_req & bus.ext_req;
    grant_valid = bus.cpu_req | bus.ext_req;
    if (tie) begin
      grant_who = ~last_grant;
    end else begin
      grant_who = bus.ext_req;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: IDLE -> ACCESS on a grant, ACCESS holds for MEM_LAT cycles, RESP lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ACCESS;
      ACCESS:  if (last_beat)   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from the registered state so they clear as soon as rst rises
  always_comb begin
    mem_en_c  = (state == ACCESS);
    mem_we_c  = (state == ACCESS) & lat_we;
    cpu_ack_c = (state == RESP) & ~owner_q;
    ext_ack_c = (state == RESP) &  owner_q;
  end

  // grant latching, beat counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      lat_we      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      owner_q     <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      if (state == IDLE && grant_valid) begin
        lat_we  <= grant_who ? bus.ext_we    : bus.cpu_we;
        addr_q  <= grant_who ? bus.ext_addr  : bus.cpu_addr;
        wdata_q <= grant_who ? bus.ext_wdata : bus.cpu_wdata;
        owner_q <= grant_who;
        cnt     <= '0;
        if (tie) last_grant <= grant_who;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (last_beat && !lat_we) begin
          if (owner_q) ext_rdata_q <= bus.mem_rdata;
          else         cpu_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cpu_ack_c;
  assign bus.ext_ack   = ext_ack_c;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.stall     = bus.cpu_req & ~cpu_ack_c;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU (fetch, lw, sw) and the external loader/debug port.
- Registered request/ack handshake per requester, fixed-latency memory sequencing, round-robin on contention.
- `stall` to the control unit holds its state while the CPU waits for its access.

Parameters:
- WIDTH, 32, data width of all data buses
- ADDR_W, 32, address width of all address buses
- MEM_LAT, 2, memory access cycles per transaction (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  CPU write enable (1 = sw, 0 = fetch/lw)
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  WIDTH  CPU store data
- cpu_rdata  output  WIDTH  CPU read data, registered
- cpu_ack  output  1  one-cycle completion pulse to CPU
- ext_req  input  1  external access request, held until ext_ack
- ext_we  input  1  external write enable
- ext_addr  input  ADDR_W  external address
- ext_wdata  input  WIDTH  external store data
- ext_rdata  output  WIDTH  external read data, registered
- ext_ack  output  1  one-cycle completion pulse to external port
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_rdata  input  WIDTH  memory read data, valid in the last access cycle
- stall  output  1  CPU waiting for memory
- owner  output  1  current/last grant (0 = CPU, 1 = EXT)

Behaviour:
- Reset values (rst=1, immediate): state IDLE; cnt 0; all of these 0:
  - mem_en, mem_we, mem_addr, mem_wdata
  - cpu_ack, ext_ack, cpu_rdata, ext_rdata
  - owner 0; last_grant = EXT, so the CPU wins the first tie.
  - Any in-flight transaction is dropped with no ack.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests each cycle.
  - Only one request: grant it.
  - Both requests: grant the requester that is not last_grant, then update last_grant.
  - On grant: latch we/addr/wdata of the winner into the mem_* registers, set owner, cnt=0, go to ACCESS.
  - No request: stay; mem_en=0.
- ACCESS:
  - mem_en=1 and mem_we=latched we for exactly MEM_LAT cycles; cnt increments each cycle.
  - mem_addr/mem_wdata are stable throughout and ignore requester input changes.
  - When cnt==MEM_LAT-1:
    - Read: capture mem_rdata into the owner's rdata register.
    - Go to RESP.
- RESP:
  - Owner's ack=1 for exactly this cycle; mem_en=0, mem_we=0.
  - Requests are ignored in this cycle; next state IDLE.
- Latency: request first seen in IDLE at cycle N -> mem_en high cycles N+1..N+MEM_LAT -> ack at N+MEM_LAT+1 -> earliest next grant sampled at N+MEM_LAT+2.
- Handshake:
  - Requester holds req and its operands stable until ack.
  - If req is still high in the cycle after ack, it is a new transaction.
  - Dropping req before ack is illegal; the arbiter completes the access anyway.
- Write transactions: rdata registers are unchanged; ack timing is identical to reads.
- rdata registers hold their value until the next completed read for that requester.
- stall = cpu_req AND NOT cpu_ack (combinational from registered state).
  - High while the CPU waits for grant or access; low in the ack cycle and when cpu_req=0.
- Starvation bound: with both requesting continuously, grants strictly alternate. Worst-case wait is 2*(MEM_LAT+2) cycles.
- Simultaneous events:
  - A request arriving during ACCESS/RESP of the other requester waits for IDLE.
  - Both acks are never high in the same cycle.
- owner holds its last value in IDLE.

Test Plan:
- Reset, then CPU-only read: MEM_LAT=2, cpu_req=1, addr=0x0000_0010, mem_rdata=0xDEAD_BEEF in the last access cycle -> mem_en high 2 cycles, cpu_ack pulses 3 cycles after request, cpu_rdata=0xDEAD_BEEF, stall high for the first 3 cycles and low at the ack.
- EXT write: ext_we=1, addr=0x20, wdata=0x1234_5678 -> mem_we=1 for 2 cycles with those values, ext_ack single pulse, ext_rdata unchanged (0).
- Contention: cpu_req and ext_req both rise at the same cycle after reset and are held -> grant order CPU, EXT, CPU, EXT; acks 4 cycles apart; never both high.
- Operand change mid-access: change cpu_addr from 0x40 to 0x44 during ACCESS -> mem_addr stays 0x40 until RESP.
- Reset mid-operation: assert rst in the second ACCESS cycle -> mem_en, acks and rdata go to 0 immediately without waiting for a clock edge. After release with req still high, a new transaction starts and acks normally.
- Back-to-back CPU: cpu_req held high across ack -> second ack arrives exactly MEM_LAT+2 cycles after the first.
